// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point window datapath: word width,
// coordinate width and the raster-tracking FSM states.
package fp_pkg;

  localparam int COORD_WIDTH = 16;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } sw_state_t;

  function automatic int fp_width(input int exp_width, input int frac_width);
    return 1 + exp_width + frac_width;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: combinational read, write-on-enable at the same
// address, so a read in the write cycle still returns the previous line's word.
module line_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 640,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/sliding_window_fp.sv
// Raster pixel stream to WINDOW_HEIGHT x WINDOW_WIDTH window of FP words with
// centre coordinates; tracks raster order and flags sync violations.
//   state    | meaning
//   WAIT_SOF | dropping pixels until a (0,0) arrives
//   RUN      | accepting pixels that match the expected raster position
module sliding_window_fp
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH       = 5,
  parameter int FRAC_WIDTH      = 10,
  parameter int WINDOW_WIDTH    = 5,
  parameter int WINDOW_HEIGHT   = 5,
  parameter int IMAGE_WIDTH     = 640,
  parameter int IMAGE_HEIGHT    = 480,
  localparam int FP_WIDTH_REG   = fp_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [FP_WIDTH_REG-1:0]                                   data_i,
  input  logic [COORD_WIDTH-1:0]                                    col_i,
  input  logic [COORD_WIDTH-1:0]                                    row_i,
  input  logic                                                      valid_i,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [COORD_WIDTH-1:0]                                    col_o,
  output logic [COORD_WIDTH-1:0]                                    row_o,
  output logic                                                      valid_o,
  output logic                                                      sync_err_o
);

  localparam int LB_AW = $clog2(IMAGE_WIDTH);
  localparam int NUM_LB = WINDOW_HEIGHT - 1;

  typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;

  sw_state_t              state, state_nxt;
  logic [COORD_WIDTH-1:0] exp_col, exp_row, exp_col_nxt, exp_row_nxt;
  logic                   accept, sync_err_nxt, emit, is_sof;

  logic [FP_WIDTH_REG-1:0]                    lb_rd [NUM_LB];
  logic [FP_WIDTH_REG-1:0]                    lb_wr [NUM_LB];
  logic [WINDOW_HEIGHT-1:0][FP_WIDTH_REG-1:0] col_vec;
  win_t                                       win_sr, win_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= WAIT_SOF;
      exp_col <= '0;
      exp_row <= '0;
    end else begin
      state   <= state_nxt;
      exp_col <= exp_col_nxt;
      exp_row <= exp_row_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    exp_col_nxt  = exp_col;
    exp_row_nxt  = exp_row;
    accept       = 1'b0;
    sync_err_nxt = 1'b0;
    is_sof       = (col_i == '0) && (row_i == '0);
    if (valid_i) begin
      unique case (state)
        WAIT_SOF: begin
          if (is_sof) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (col_i == exp_col && row_i == exp_row) begin
            accept = 1'b1;
          end else if (is_sof) begin
            accept       = 1'b1;
            sync_err_nxt = 1'b1;
          end else begin
            sync_err_nxt = 1'b1;
            state_nxt    = WAIT_SOF;
          end
        end
        default: state_nxt = WAIT_SOF;
      endcase
    end
    // Advancing from the accepted pixel also realigns the counters after a restart.
    if (accept) begin
      if (col_i == COORD_WIDTH'(IMAGE_WIDTH - 1)) begin
        exp_col_nxt = '0;
        exp_row_nxt = (row_i == COORD_WIDTH'(IMAGE_HEIGHT - 1)) ? '0 : row_i + 1'b1;
      end else begin
        exp_col_nxt = col_i + 1'b1;
        exp_row_nxt = row_i;
      end
    end
  end

  for (genvar j = 0; j < NUM_LB; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_wr[j] = data_i;
    end else begin : g_chain
      assign lb_wr[j] = lb_rd[j-1];
    end
    line_buffer #(
      .WIDTH (FP_WIDTH_REG),
      .DEPTH (IMAGE_WIDTH)
    ) u_line_buffer (
      .clk_i   (clk_i),
      .we_i    (accept),
      .addr_i  (col_i[LB_AW-1:0]),
      .wdata_i (lb_wr[j]),
      .rdata_o (lb_rd[j])
    );
  end

  always_comb begin
    col_vec = '0;
    col_vec[WINDOW_HEIGHT-1] = data_i;
    for (int k = 0; k < NUM_LB; k++) col_vec[k] = lb_rd[NUM_LB-1-k];
  end

  always_comb begin
    win_nxt = win_sr;
    for (int r = 0; r < WINDOW_HEIGHT; r++) begin
      for (int c = 0; c < WINDOW_WIDTH - 1; c++) win_nxt[r][c] = win_sr[r][c+1];
      win_nxt[r][WINDOW_WIDTH-1] = col_vec[r];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) win_sr <= win_nxt;
  end

  assign emit = accept && (row_i >= COORD_WIDTH'(WINDOW_HEIGHT - 1))
                       && (col_i >= COORD_WIDTH'(WINDOW_WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      window_o   <= '0;
      col_o      <= '0;
      row_o      <= '0;
      valid_o    <= 1'b0;
      sync_err_o <= 1'b0;
    end else begin
      valid_o    <= emit;
      sync_err_o <= sync_err_nxt;
      if (emit) begin
        window_o <= win_nxt;
        col_o    <= col_i - COORD_WIDTH'(WINDOW_WIDTH / 2);
        row_o    <= row_i - COORD_WIDTH'(WINDOW_HEIGHT / 2);
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_fp.sv
// Self-checking bench for sliding_window_fp on an 8x6 image with a 5x5 window;
// an image-array reference model is compared against the DUT every cycle.
module tb_sliding_window_fp;

  localparam int IW = 8;
  localparam int IH = 6;
  localparam int WW = 5;
  localparam int WH = 5;
  localparam int FW = 16;
  localparam int NPIX = IW * IH;

  typedef logic [WH-1:0][WW-1:0][FW-1:0] win_t;
  typedef struct {
    logic [15:0] col;
    logic [15:0] row;
    win_t        win;
  } rec_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [FW-1:0] data_i;
  logic [15:0]   col_i, row_i;
  logic          valid_i;
  win_t          window_o;
  logic [15:0]   col_o, row_o;
  logic          valid_o, sync_err_o;

  sliding_window_fp #(
    .EXP_WIDTH     (5),
    .FRAC_WIDTH    (10),
    .WINDOW_WIDTH  (WW),
    .WINDOW_HEIGHT (WH),
    .IMAGE_WIDTH   (IW),
    .IMAGE_HEIGHT  (IH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .col_i      (col_i),
    .row_i      (row_i),
    .valid_i    (valid_i),
    .window_o   (window_o),
    .col_o      (col_o),
    .row_o      (row_o),
    .valid_o    (valid_o),
    .sync_err_o (sync_err_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   fails  = 0;
  bit   chk_en = 1'b0;
  rec_t vq[$];
  rec_t ref_q[$];
  int   errcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model: raster tracking plus a plain image array of the current frame.
  logic [FW-1:0] img [IH][IW];
  bit            m_run, m_acc;
  int            m_ec, m_er, mc, mr;
  logic          m_valid, m_err;
  logic [15:0]   m_col, m_row;
  win_t          m_win;

  always @(posedge clk_i) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst_i) begin
      m_run = 1'b0; m_ec = 0; m_er = 0;
      m_col = '0; m_row = '0; m_win = '0;
    end else if (valid_i) begin
      mc = int'(col_i);
      mr = int'(row_i);
      m_acc = 1'b0;
      if (!m_run) begin
        if (mc == 0 && mr == 0) begin m_acc = 1'b1; m_run = 1'b1; end
      end else if (mc == m_ec && mr == m_er) begin
        m_acc = 1'b1;
      end else if (mc == 0 && mr == 0) begin
        m_acc = 1'b1; m_err = 1'b1;
      end else begin
        m_err = 1'b1; m_run = 1'b0;
      end
      if (m_acc) begin
        img[mr][mc] = data_i;
        m_ec = (mc + 1) % IW;
        m_er = (mc == IW - 1) ? (mr + 1) % IH : mr;
        if (mr >= WH - 1 && mc >= WW - 1) begin
          m_valid = 1'b1;
          m_col   = 16'(mc - WW / 2);
          m_row   = 16'(mr - WH / 2);
          for (int i = 0; i < WH; i++)
            for (int j = 0; j < WW; j++)
              m_win[i][j] = img[mr - (WH - 1) + i][mc - (WW - 1) + j];
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("sync_err_o", 32'(sync_err_o), 32'(m_err));
      chk("col_o", 32'(col_o), 32'(m_col));
      chk("row_o", 32'(row_o), 32'(m_row));
      checks++;
      if (window_o !== m_win) begin
        fails++;
        $display("FAIL window_o: got %h expected %h", window_o, m_win);
      end
      if (valid_o === 1'b1) vq.push_back('{col: col_o, row: row_o, win: window_o});
      if (sync_err_o === 1'b1) errcnt++;
    end
  end

  task automatic send_px(input int c, input int r);
    @(negedge clk_i);
    valid_i = 1'b1;
    col_i   = 16'(c);
    row_i   = 16'(r);
    data_i  = {r[7:0], c[7:0]};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      col_i   = 16'($urandom);
      row_i   = 16'($urandom);
      data_i  = 16'($urandom);
    end
  endtask

  task automatic send_range(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      while (gaps && $urandom_range(0, 1) == 1) idle(1);
      send_px(i % IW, i / IW);
    end
  endtask

  task automatic chk_frame(input string tag, input int base);
    chk({tag, " first col_o"}, 32'(vq[base].col), 32'd2);
    chk({tag, " first row_o"}, 32'(vq[base].row), 32'd2);
    chk({tag, " first w00"}, 32'(vq[base].win[0][0]), 32'h0000);
    chk({tag, " first w44"}, 32'(vq[base].win[4][4]), 32'h0404);
    chk({tag, " first w22"}, 32'(vq[base].win[2][2]), 32'h0202);
    chk({tag, " last col_o"}, 32'(vq[base+7].col), 32'd5);
    chk({tag, " last row_o"}, 32'(vq[base+7].row), 32'd3);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; col_i = '0; row_i = '0; data_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i  = 1'b0;
    chk_en = 1'b1;
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset col_o", 32'(col_o), 32'd0);
    chk("reset window_o", 32'(window_o == '0), 32'd1);

    // Full frame, continuous valid.
    send_range(0, NPIX - 1, 1'b0);
    idle(3);
    chk("full count", 32'(vq.size()), 32'd8);
    if (vq.size() == 8) chk_frame("full", 0);
    ref_q = vq;
    vq.delete();

    // Same frame with random gaps must give the identical window sequence.
    send_range(0, NPIX - 1, 1'b1);
    idle(3);
    chk("gaps count", 32'(vq.size()), 32'd8);
    if (vq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("gaps col_o", 32'(vq[i].col), 32'(ref_q[i].col));
        chk("gaps row_o", 32'(vq[i].row), 32'(ref_q[i].row));
        chk("gaps window", 32'(vq[i].win == ref_q[i].win), 32'd1);
      end
    end
    vq.delete();

    // Two back-to-back frames.
    send_range(0, NPIX - 1, 1'b0);
    send_range(0, NPIX - 1, 1'b0);
    idle(3);
    chk("b2b count", 32'(vq.size()), 32'd16);
    if (vq.size() == 16) chk_frame("b2b frame2", 8);
    vq.delete();

    // Mid-stream reset, then pixels that are not a start of frame.
    send_range(0, 26, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst valid_o", 32'(valid_o), 32'd0);
    chk("midrst row_o", 32'(row_o), 32'd0);
    chk("midrst window_o", 32'(window_o == '0), 32'd1);
    send_px(4, 4);
    send_px(5, 4);
    send_range(40, NPIX - 1, 1'b0);
    idle(3);
    chk("midrst no window", 32'(vq.size()), 32'd0);
    send_range(0, NPIX - 1, 1'b0);
    idle(3);
    chk("midrst refill count", 32'(vq.size()), 32'd8);
    if (vq.size() == 8) chk_frame("midrst", 0);
    vq.delete();
    errcnt = 0;

    // Sync error: (3,2) where (2,2) is expected.
    send_range(0, 2 * IW + 1, 1'b0);
    send_px(3, 2);
    send_range(2 * IW + 4, NPIX - 1, 1'b0);
    idle(3);
    chk("syncerr pulses", 32'(errcnt), 32'd1);
    chk("syncerr no window", 32'(vq.size()), 32'd0);
    send_range(0, NPIX - 1, 1'b0);
    idle(3);
    chk("syncerr recover count", 32'(vq.size()), 32'd8);
    chk("syncerr no more pulses", 32'(errcnt), 32'd1);
    vq.delete();
    errcnt = 0;

    // Early restart: (0,0) where (5,3) is expected.
    send_range(0, 3 * IW + 4, 1'b0);
    send_range(0, NPIX - 1, 1'b0);
    idle(3);
    chk("restart pulses", 32'(errcnt), 32'd1);
    chk("restart count", 32'(vq.size()), 32'd8);
    if (vq.size() == 8) chk_frame("restart", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sliding_window_fp.md
Name: sliding_window_fp

Overview:
- Producer side of the window interface consumed by the floating-point convolution wrappers.
- Converts a raster-order pixel stream (data, col, row, valid) into a WINDOW_HEIGHT x WINDOW_WIDTH window of FP words, with the centre-pixel coordinates and a valid strobe.
- Window rows are built from line buffers; window columns are built from a shift register.
- Output connects directly to window_i/col_i/row_i/valid_i of any convolution wrapper.

Parameters:
- EXP_WIDTH, 5, exponent bits.
- FRAC_WIDTH, 10, fraction bits.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, word width (local).
- WINDOW_WIDTH, 5, window columns; odd, ≥3.
- WINDOW_HEIGHT, 5, window rows; odd, ≥3.
- IMAGE_WIDTH, 640, pixels per line; ≥ WINDOW_WIDTH.
- IMAGE_HEIGHT, 480, lines per frame; ≥ WINDOW_HEIGHT.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  FP_WIDTH_REG  input pixel.
- col_i  in  16  input pixel column.
- row_i  in  16  input pixel row.
- valid_i  in  1  pixel qualifier; no backpressure.
- window_o  out  [WINDOW_HEIGHT][WINDOW_WIDTH] x FP_WIDTH_REG  window; [0][0] = oldest row, leftmost column.
- col_o  out  16  centre column.
- row_o  out  16  centre row.
- valid_o  out  1  window qualifier.
- sync_err_o  out  1  one-cycle pulse on a raster-order violation.

Behaviour:
- Reset (synchronous, active-high, takes priority):
  - All outputs go to 0.
  - FSM goes to WAIT_SOF.
  - Expected column and row counters go to 0.
  - Line buffer and shift register contents are don't-care; no window is emitted until they are refilled.
- FSM states:
  - WAIT_SOF: drop pixels until valid_i with col_i==0 and row_i==0. That pixel is processed normally and the FSM moves to RUN.
  - RUN: on each valid_i, compare (col_i,row_i) with the expected counters.
    - Match: process the pixel, then advance the counters. Column wraps at IMAGE_WIDTH-1 and increments row. Row wraps at IMAGE_HEIGHT-1 to (0,0); the FSM stays in RUN, so back-to-back frames are legal.
    - Mismatch at (0,0): assert sync_err_o and treat the pixel as the start of a new frame (early restart).
    - Any other mismatch: assert sync_err_o, drop the pixel, go to WAIT_SOF.
- Pixel processing, when valid_i and the pixel is accepted:
  - The line buffers form a chain of WINDOW_HEIGHT-1 buffers, each IMAGE_WIDTH deep, addressed by col_i, with read-before-write.
  - New column vector: element WINDOW_HEIGHT-1 = data_i; element k = lb[WINDOW_HEIGHT-2-k][col_i].
  - lb[0][col_i] <= data_i; lb[j][col_i] <= lb[j-1][col_i] (old value).
  - Shift register: each window column shifts left by one; the new column enters at index WINDOW_WIDTH-1.
- No state changes when valid_i is low.
- Output (latency 1 cycle from the completing pixel):
  - valid_o=1 when the accepted pixel has row_i ≥ WINDOW_HEIGHT-1 and col_i ≥ WINDOW_WIDTH-1.
  - col_o = col_i - WINDOW_WIDTH/2; row_o = row_i - WINDOW_HEIGHT/2 (integer division).
  - No padding: border centres are never emitted.
  - Valid outputs per frame: (IMAGE_WIDTH-WINDOW_WIDTH+1)*(IMAGE_HEIGHT-WINDOW_HEIGHT+1).
- When valid_o is low, window_o/col_o/row_o hold their last values.
- Column wrap: windows are never emitted for col_i < WINDOW_WIDTH-1, so stale columns from the previous line are never visible.
- sync_err_o and a dropped pixel cannot produce valid_o in the same cycle.
- Data is passed through bit-exact; no FP arithmetic; NaN/Inf are not interpreted.

Decomposition:
- Shared package (fp_pkg, extend if present):
  - FP width function of EXP_WIDTH/FRAC_WIDTH.
  - Coordinate width constant (16).
  - FSM state enum {WAIT_SOF, RUN}.
- One sub-module: line_buffer.
  - Parameterised by width and depth.
  - Combinational read at the address, write on enable at the same address.
  - Read returns the old value.
  - Instantiated WINDOW_HEIGHT-1 times in a generate loop.

Test Plan:
- Common bench setup: IMAGE_WIDTH=8, IMAGE_HEIGHT=6, 5x5 window. Pixel value = {row[7:0],col[7:0]} as raw 16-bit words.
1. Reset: assert rst_i for 2 cycles mid-stream -> every output is 0 the cycle after; no valid_o until (0,0) is re-sent and 4 full rows are refilled.
2. Full frame, valid_i constant:
   - First valid_o occurs 1 cycle after input (4,4), with col_o=2, row_o=2, window_o[0][0]=0x0000, window_o[4][4]=0x0404, window_o[2][2]=0x0202.
   - Exactly 8 valid_o per frame; the last has col_o=5, row_o=3.
3. Random valid_i gaps (50% duty) -> the valid_o/window sequence is identical to scenario 2; outputs hold their values through gaps.
4. Two back-to-back frames -> frame 2 emits nothing before its (4,4). Its first window has [0][0]=0x0000 and [4][4]=0x0404 (no frame-1 rows, checked by value).
5. Sync error: send (3,2) where (2,2) is expected -> sync_err_o=1 for exactly 1 cycle, FSM goes to WAIT_SOF, and there is no valid_o until the new frame reaches (4,4).
6. Early restart: send (0,0) at expected (5,3) -> sync_err_o pulses once and the new frame proceeds as in scenario 2 with no second error pulse.
